// File: rtl/fir_channel_sequencer_pkg.sv
// rtl/fir_channel_sequencer_pkg.sv - shared audio constants, channel encoding and sequencer state enum
package fir_channel_sequencer_pkg;

    localparam int PCM_W = 24;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } seq_state_t;

    // Index width that stays legal when only one item exists
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_channel_sequencer_if.sv
// rtl/fir_channel_sequencer_if.sv - sample input, history RAM and MAC issue bundle of the sequencer
interface fir_channel_sequencer_if #(
    parameter int NUM_FILTERS = 4,
    parameter int HIST_AW     = 8
);
    import fir_channel_sequencer_pkg::*;

    localparam int FW = idx_w(NUM_FILTERS);

    logic              audio_en;
    logic [7:0]        taps_per_filter;
    logic              overrun_clr;
    logic              l_data_en;
    logic              r_data_en;
    logic [PCM_W-1:0]  l_data_in;
    logic [PCM_W-1:0]  r_data_in;

    logic              hist_wr_en;
    logic              hist_wr_chan;
    logic [HIST_AW-1:0] hist_wr_addr;
    logic [PCM_W-1:0]  hist_wr_data;
    logic              mac_valid;
    logic              mac_clear;
    logic              mac_last;
    logic              mac_chan;
    logic [FW-1:0]     mac_filter;
    logic [FW+7:0]     coef_addr;
    logic [HIST_AW-1:0] hist_rd_addr;
    logic              l_done;
    logic              r_done;
    logic              busy;
    logic [1:0]        overrun;

    modport master (
        output audio_en, taps_per_filter, overrun_clr,
               l_data_en, r_data_en, l_data_in, r_data_in,
        input  hist_wr_en, hist_wr_chan, hist_wr_addr, hist_wr_data,
               mac_valid, mac_clear, mac_last, mac_chan, mac_filter,
               coef_addr, hist_rd_addr, l_done, r_done, busy, overrun
    );

    modport slave (
        input  audio_en, taps_per_filter, overrun_clr,
               l_data_en, r_data_en, l_data_in, r_data_in,
        output hist_wr_en, hist_wr_chan, hist_wr_addr, hist_wr_data,
               mac_valid, mac_clear, mac_last, mac_chan, mac_filter,
               coef_addr, hist_rd_addr, l_done, r_done, busy, overrun
    );

endinterface

// File: rtl/fir_sample_buffer.sv
// rtl/fir_sample_buffer.sv - one-deep per-channel sample holding register with pending and sticky overrun
module fir_sample_buffer
    import fir_channel_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_strobe,
    input  logic [PCM_W-1:0] i_data,
    input  logic             i_load,
    input  logic             i_overrun_clr,
    output logic [PCM_W-1:0] o_data,
    output logic             o_pending,
    output logic             o_overrun
);

    logic [PCM_W-1:0] r_data;
    logic             r_pending;
    logic             r_overrun;

    // A strobe landing on an unconsumed sample replaces it and marks the loss; the set beats a clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data    <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (i_strobe) begin
                r_data <= i_data;
            end

            if (i_flush) begin
                r_pending <= 1'b0;
            end else if (i_strobe) begin
                r_pending <= 1'b1;
            end else if (i_load) begin
                r_pending <= 1'b0;
            end

            if (i_strobe && r_pending && !i_load) begin
                r_overrun <= 1'b1;
            end else if (i_overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_pending = r_pending;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/fir_channel_sequencer.sv
// rtl/fir_channel_sequencer.sv - shares one FIR MAC engine between left and right PCM channels
module fir_channel_sequencer
    import fir_channel_sequencer_pkg::*;
#(
    parameter int NUM_FILTERS = 4,
    parameter int MAC_LATENCY = 3,
    parameter int HIST_AW     = 8
)(
    input  logic clk,
    input  logic reset,
    fir_channel_sequencer_if.slave bus
);

    localparam int FW = idx_w(NUM_FILTERS);
    localparam int CW = FW + 8;
    localparam int DW = idx_w(MAC_LATENCY);

    seq_state_t         r_state;
    seq_state_t         w_next_state;
    logic               r_chan;
    logic               w_next_chan;
    logic               r_last_served;
    logic [HIST_AW-1:0] r_wr_ptr [0:1];
    logic [7:0]         r_taps;
    logic [7:0]         r_tap;
    logic [FW-1:0]      r_filter;
    logic [CW-1:0]      r_coef;
    logic [DW-1:0]      r_drain;

    logic               w_l_stb, w_r_stb;
    logic               w_l_pend, w_r_pend;
    logic               w_l_ovr, w_r_ovr;
    logic [PCM_W-1:0]   w_l_data, w_r_data;
    logic               w_req_l, w_req_r, w_req_any, w_pick;
    logic               w_do_load;
    logic               w_last_tap, w_run_done, w_drain_done;

    assign w_l_stb   = bus.audio_en & bus.l_data_en;
    assign w_r_stb   = bus.audio_en & bus.r_data_en;
    assign w_do_load = (r_state == LOAD) & bus.audio_en;

    fir_sample_buffer u_buf_l (
        .clk           (clk),
        .reset         (reset),
        .i_flush       (!bus.audio_en),
        .i_strobe      (w_l_stb),
        .i_data        (bus.l_data_in),
        .i_load        (w_do_load & (r_chan == CH_LEFT)),
        .i_overrun_clr (bus.overrun_clr),
        .o_data        (w_l_data),
        .o_pending     (w_l_pend),
        .o_overrun     (w_l_ovr)
    );

    fir_sample_buffer u_buf_r (
        .clk           (clk),
        .reset         (reset),
        .i_flush       (!bus.audio_en),
        .i_strobe      (w_r_stb),
        .i_data        (bus.r_data_in),
        .i_load        (w_do_load & (r_chan == CH_RIGHT)),
        .i_overrun_clr (bus.overrun_clr),
        .o_data        (w_r_data),
        .o_pending     (w_r_pend),
        .o_overrun     (w_r_ovr)
    );

    // A same-cycle strobe counts as a request so an idle engine starts without an extra wait
    assign w_req_l      = w_l_pend | w_l_stb;
    assign w_req_r      = w_r_pend | w_r_stb;
    assign w_req_any    = w_req_l | w_req_r;
    assign w_pick       = w_req_r & (!w_req_l | (r_last_served == CH_LEFT));
    assign w_last_tap   = (r_tap == r_taps - 8'd1);
    assign w_run_done   = w_last_tap & (r_filter == FW'(NUM_FILTERS - 1));
    assign w_drain_done = (r_drain == DW'(MAC_LATENCY - 1));

    // State and served-channel register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_chan  <= CH_LEFT;
        end else begin
            r_state <= w_next_state;
            r_chan  <= w_next_chan;
        end
    end

    // Write pointers, tap/band/coefficient counters and drain timer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr[0]   <= '0;
            r_wr_ptr[1]   <= '0;
            r_last_served <= CH_RIGHT;
            r_taps        <= 8'd1;
            r_tap         <= '0;
            r_filter      <= '0;
            r_coef        <= '0;
            r_drain       <= '0;
        end else begin
            if (w_do_load) begin
                r_wr_ptr[r_chan] <= r_wr_ptr[r_chan] + HIST_AW'(1);
                r_last_served    <= r_chan;
                r_taps           <= (bus.taps_per_filter == 8'd0) ? 8'd1 : bus.taps_per_filter;
                r_tap            <= '0;
                r_filter         <= '0;
                r_coef           <= '0;
            end
            if (r_state == RUN) begin
                r_coef  <= r_coef + CW'(1);
                r_drain <= '0;
                if (w_last_tap) begin
                    r_tap    <= '0;
                    r_filter <= r_filter + FW'(1);
                end else begin
                    r_tap <= r_tap + 8'd1;
                end
            end
            if (r_state == DRAIN) begin
                r_drain <= r_drain + DW'(1);
            end
        end
    end

    // Next state and outputs; dropping audio_en silences every strobe at once
    always_comb begin
        w_next_state     = r_state;
        w_next_chan      = r_chan;
        bus.hist_wr_en   = 1'b0;
        bus.hist_wr_chan = 1'b0;
        bus.hist_wr_addr = '0;
        bus.hist_wr_data = '0;
        bus.mac_valid    = 1'b0;
        bus.mac_clear    = 1'b0;
        bus.mac_last     = 1'b0;
        bus.mac_chan     = 1'b0;
        bus.mac_filter   = '0;
        bus.coef_addr    = '0;
        bus.hist_rd_addr = '0;
        bus.l_done       = 1'b0;
        bus.r_done       = 1'b0;
        bus.busy         = (r_state != IDLE);
        bus.overrun      = {w_r_ovr, w_l_ovr};

        if (!bus.audio_en) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_any) begin
                        w_next_state = LOAD;
                        w_next_chan  = w_pick;
                    end
                end
                LOAD: begin
                    bus.hist_wr_en   = 1'b1;
                    bus.hist_wr_chan = r_chan;
                    bus.hist_wr_addr = r_wr_ptr[r_chan] + HIST_AW'(1);
                    bus.hist_wr_data = (r_chan == CH_RIGHT) ? w_r_data : w_l_data;
                    w_next_state     = RUN;
                end
                RUN: begin
                    bus.mac_valid    = 1'b1;
                    bus.mac_clear    = (r_tap == 8'd0);
                    bus.mac_last     = w_last_tap;
                    bus.mac_chan     = r_chan;
                    bus.mac_filter   = r_filter;
                    bus.coef_addr    = r_coef;
                    bus.hist_rd_addr = r_wr_ptr[r_chan] - HIST_AW'(r_tap);
                    if (w_run_done) begin
                        w_next_state = DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_drain_done) begin
                        bus.l_done = (r_chan == CH_LEFT);
                        bus.r_done = (r_chan == CH_RIGHT);
                        if (w_req_any) begin
                            w_next_state = LOAD;
                            w_next_chan  = w_pick;
                        end else begin
                            w_next_state = IDLE;
                        end
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

endmodule
